// File: rtl/serial_nibble_loader_pkg.sv
// serial_nibble_loader_pkg: shared FSM state encoding and default word width
package serial_nibble_loader_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;
endpackage

// File: rtl/serial_nibble_loader_shifter.sv
// nibble_shifter: shift register, bit counter and last-bit detect for the serial loader
module nibble_shifter #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             flush,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] nxt,
    output logic             last
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    assign nxt  = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (clear || flush) begin
            sr  <= '0;
            cnt <= '0;
        end else if (shift_en) begin
            sr  <= nxt;
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader: serial-to-parallel frame FSM driving a downstream register's d/load
module serial_nibble_loader
    import serial_nibble_loader_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] d,
    output logic             load,
    output logic             busy,
    output logic             overrun
);
    state_t           state, state_n;
    logic             flush, shift_en, ovr_set, last;
    logic [WIDTH-1:0] nxt;
    nibble_shifter #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_shifter (
        .clk(clk), .clear(clear), .flush(flush), .shift_en(shift_en),
        .sin(sin), .nxt(nxt), .last(last)
    );
    always_comb begin
        state_n  = state;
        flush    = 1'b0;
        shift_en = 1'b0;
        ovr_set  = 1'b0;
        case (state)
            IDLE: begin
                state_n = start ? SHIFT : IDLE;
                flush   = start;
            end
            SHIFT: begin
                if (abort) begin
                    state_n = IDLE;
                    flush   = 1'b1;
                end else if (start) begin
                    ovr_set = 1'b1;
                    flush   = 1'b1;
                end else if (sin_valid) begin
                    shift_en = 1'b1;
                    state_n  = last ? LOAD : SHIFT;
                end
            end
            LOAD: begin
                state_n = IDLE;
                ovr_set = start | sin_valid;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            d       <= '0;
            load    <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_n;
            load    <= state_n == LOAD;
            busy    <= state_n != IDLE;
            overrun <= overrun | ovr_set;
            if (shift_en && last) d <= nxt;
        end
    end
endmodule

// File: tb/tb_serial_nibble_loader.sv
// tb_serial_nibble_loader: scoreboard bench for MSB-first and LSB-first loader instances
module tb_serial_nibble_loader;
    logic       clk = 1'b0;
    logic       clear = 1'b0, start = 1'b0, sin = 1'b0, sin_valid = 1'b0, abort = 1'b0;
    logic [3:0] dm, dl;
    logic       lm, ll, bm, bl, om, ol;
    logic [3:0] qm[$], ql[$];
    int         checks = 0, errors = 0;
    always #5 clk = ~clk;
    serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clear(clear), .start(start), .sin(sin), .sin_valid(sin_valid),
        .abort(abort), .d(dm), .load(lm), .busy(bm), .overrun(om)
    );
    serial_nibble_loader #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clear(clear), .start(start), .sin(sin), .sin_valid(sin_valid),
        .abort(abort), .d(dl), .load(ll), .busy(bl), .overrun(ol)
    );
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic logic [3:0] rev(input logic [3:0] w);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = w[3-i];
        return r;
    endfunction
    always @(negedge clk) begin
        if (lm) begin
            if (qm.size() == 0) chk("unexpected_load_m", 8'(dm), 8'hff);
            else chk("d_msb", 8'(dm), 8'(qm.pop_front()));
        end
        if (ll) begin
            if (ql.size() == 0) chk("unexpected_load_l", 8'(dl), 8'hff);
            else chk("d_lsb", 8'(dl), 8'(ql.pop_front()));
        end
    end
    task automatic step(input logic st, input logic s, input logic v, input logic ab, input logic cl);
        start = st; sin = s; sin_valid = v; abort = ab; clear = cl;
        @(posedge clk);
        #1;
        start = 1'b0; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0; clear = 1'b0;
    endtask
    task automatic send_bits(input logic [3:0] w, input int gap, input logic post_vld, input logic post_clr);
        qm.push_back(w);
        ql.push_back(rev(w));
        for (int i = 3; i >= 0; i--) begin
            if (i != 3) repeat (gap) begin
                step(0, 0, 0, 0, 0);
                chk("busy_gap", 8'(bm), 8'd1);
            end
            step(0, w[i], 1, 0, 0);
        end
        chk("load_latency_m", 8'(lm), 8'd1);
        chk("load_latency_l", 8'(ll), 8'd1);
        step(0, 0, post_vld, 0, post_clr);
        chk("load_one_cycle_m", 8'(lm), 8'd0);
        chk("load_one_cycle_l", 8'(ll), 8'd0);
        chk("busy_after_m", 8'(bm), 8'd0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        step(0, 0, 0, 0, 1);
        chk("rst_d_m", 8'(dm), 8'd0);
        chk("rst_d_l", 8'(dl), 8'd0);
        chk("rst_load", 8'({lm, ll}), 8'd0);
        chk("rst_busy", 8'({bm, bl}), 8'd0);
        chk("rst_overrun", 8'({om, ol}), 8'd0);
        // basic frame, start and sin_valid together must not accept a bit
        step(1, 1, 1, 0, 0);
        chk("busy_shift", 8'(bm), 8'd1);
        send_bits(4'b1011, 0, 0, 0);
        chk("d_hold_basic", 8'(dm), 8'hb);
        chk("overrun_basic", 8'(om), 8'd0);
        step(1, 0, 0, 0, 0);
        send_bits(4'b1000, 2, 0, 0);
        chk("d_lsb_gapped", 8'(dl), 8'h1);
        step(1, 0, 0, 0, 0);
        send_bits(4'b1011, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        chk("abort_busy", 8'(bm), 8'd0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("abort_d_m", 8'(dm), 8'hb);
        chk("abort_d_l", 8'(dl), 8'hd);
        chk("abort_no_load", 8'({lm, ll}), 8'd0);
        chk("abort_overrun", 8'(om), 8'd0);
        step(1, 0, 0, 0, 0);
        send_bits(4'b1011, 0, 1, 0);
        chk("overrun_set", 8'({om, ol}), 8'h3);
        step(1, 0, 0, 0, 0);
        send_bits(4'b0110, 0, 0, 0);
        chk("overrun_sticky", 8'(om), 8'd1);
        chk("d_0110", 8'(dm), 8'h6);
        step(0, 0, 0, 0, 1);
        chk("overrun_cleared", 8'({om, ol}), 8'd0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 1);
        chk("clr_mid_d", 8'({dm, dl}), 8'd0);
        chk("clr_mid_busy", 8'({bm, bl}), 8'd0);
        step(0, 1, 1, 0, 0);
        chk("clr_mid_no_load", 8'({lm, ll}), 8'd0);
        step(1, 0, 0, 0, 0);
        send_bits(4'b0101, 0, 0, 1);
        chk("clr_load_d", 8'({dm, dl}), 8'd0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("restart_overrun", 8'({om, ol}), 8'h3);
        chk("restart_busy", 8'(bm), 8'd1);
        send_bits(4'b0111, 0, 0, 0);
        chk("restart_d_m", 8'(dm), 8'h7);
        chk("restart_d_l", 8'(dl), 8'he);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("qm_drained", 8'(qm.size()), 8'd0);
        chk("ql_drained", 8'(ql.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
